spi_master_arb: RTL and testbench
=================================

Name: spi_master_arb

Overview:
- SPI master that shares one 8-bit SPI link between NUM_REQ on-chip requesters.
- Round-robin arbiter picks one requester per transfer. A sequencer then drives cs/sclk/mosi, runs a full 8-bit transfer and returns the captured miso byte.
- Sits between internal bus clients and the board-level SPI slave; sclk is derived from clk.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- DATA_W, 8, bits per transfer, MSB first.
- CLK_DIV, 4, clk cycles per sclk half-period (>=2).
- CS_GAP, 2, clk cycles cs held high after a transfer before the next grant (>=1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester transfer request, level, held until gnt.
- req_data  in  NUM_REQ*DATA_W  tx byte for requester i in slice [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse when the request is accepted.
- busy  out  1  high from grant until the end of HOLD.
- done  out  1  1-cycle pulse when rx_data is valid.
- done_id  out  $clog2(NUM_REQ) (min 1)  index of the requester the done belongs to.
- rx_data  out  DATA_W  byte captured from miso.
- sclk  out  1  SPI clock, idle low.
- cs  out  1  chip select, active low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.

Behaviour:
- Reset values: sclk=0, cs=1, mosi=0, gnt=0, busy=0, done=0, done_id=0, rx_data=0, state=IDLE, RR pointer prefers requester 0.
- Reset mid-transfer aborts the transfer at the same edge: cs=1, sclk=0, no done.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE, any req high:
  - Arbiter selects the first requester at or after the RR pointer.
  - Same edge: tx shift register is loaded from req_data; gnt[i]=1 for one cycle; cs=0; mosi=tx[DATA_W-1]; busy=1; state=SETUP.
  - RR pointer moves to i+1 (wraps to 0).
  - Edge E0 denotes this grant edge.
- SETUP: waits CLK_DIV cycles, then first sclk rise at E0+CLK_DIV; state=SHIFT.
- SHIFT: sclk toggles every CLK_DIV cycles; toggle k occurs at E0+k*CLK_DIV, k=1..2*DATA_W.
  - Odd k (rise): no datapath change.
  - Even k (fall): miso is shifted into rx shift register LSB.
  - Even k < 2*DATA_W (fall): mosi advances to the next bit.
- Last fall, k=2*DATA_W, at E0+2*DATA_W*CLK_DIV (64 cycles at defaults):
  - rx_data = full captured byte, done=1, done_id=i, cs=1, sclk=0, mosi=0.
  - state=HOLD.
- HOLD: cs stays high for CS_GAP cycles, then busy=0 and state=IDLE. A new grant is possible on the first IDLE edge.
- req changes during a transfer are ignored. A requester dropping req before its gnt is simply not served.
- gnt is never asserted while busy=1.
- tx data is latched at grant; later req_data changes do not affect the transfer.

Optional Feature:
- Macro SPI_LOOPBACK_EN.
- Defined: miso port is ignored; rx shift register samples the internal mosi value at each fall, so rx_data == transmitted byte. Used for bring-up and self-test.
- Undefined: miso port is used as described above.

Decomposition:
- Package spi_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, HOLD);
  - SPI_DATA_W=8 default;
  - minimum constants for CLK_DIV and CS_GAP.
- Sub-module spi_rr_arbiter (NUM_REQ): inputs req, pointer, enable; outputs one-hot grant and index. Purely the selection logic; the pointer register lives in the parent.

Test Plan:
- Reset then req=01, req_data[7:0]=0xA5, miso driven by a model returning 0x3C -> gnt=01 at E0; mosi bits 1,0,1,0,0,1,0,1 sampled at sclk rises; done at E0+64 with rx_data=0x3C, done_id=0.
- req=11 held continuously -> grants alternate 01,10,01; each grant follows the previous done by exactly CS_GAP+1 cycles; cs high >= CS_GAP cycles between bytes.
- rst_n=0 at E0+20 mid-transfer -> same edge cs=1, sclk=0, busy=0; no done; next grant goes to requester 0.
- Change req_data to 0xFF at E0+5 while 0x81 is in flight -> transmitted byte is still 0x81.
- req pulsed for requester 1 only while busy, dropped before HOLD ends -> no gnt, no extra transfer.
- With SPI_LOOPBACK_EN, req_data=0x5A -> rx_data=0x5A at done, miso port toggled randomly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the arbitrated SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  localparam int unsigned SPI_DATA_W      = 8;
  localparam int unsigned SPI_CLK_DIV_MIN = 2;
  localparam int unsigned SPI_CS_GAP_MIN  = 1;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int unsigned spi_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin selection: first requester at or after ptr wins. The pointer
// register itself lives in the parent.
module spi_rr_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = spi_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0]   idx_c
);

  // One extra bit so ptr + offset never overflows before the wrap.
  localparam int unsigned SUM_W = IDX_W + 1;

  logic             found;
  logic [SUM_W-1:0] cand;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + SUM_W'(i);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      if (en && !found && req[cand[IDX_W-1:0]]) begin
        found                   = 1'b1;
        gnt_c[cand[IDX_W-1:0]]  = 1'b1;
        idx_c                   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_master_arb.sv
// SPI master shared by NUM_REQ requesters through a round-robin arbiter.
// Build option SPI_LOOPBACK_EN: rx captures the outgoing mosi bit instead of miso.
module spi_master_arb
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = SPI_DATA_W,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          busy,
  output logic                          done,
  output logic [spi_idx_w(NUM_REQ)-1:0] done_id,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          sclk,
  output logic                          cs,
  output logic                          mosi,
  input  logic                          miso
);

  localparam int unsigned IDX_W   = spi_idx_w(NUM_REQ);
  localparam int unsigned DIV     = (CLK_DIV < SPI_CLK_DIV_MIN) ? SPI_CLK_DIV_MIN : CLK_DIV;
  localparam int unsigned GAP     = (CS_GAP < SPI_CS_GAP_MIN) ? SPI_CS_GAP_MIN : CS_GAP;
  localparam int unsigned CNT_MAX = (DIV > GAP) ? DIV : GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned NUM_TOG = 2 * DATA_W;
  localparam int unsigned TOG_W   = $clog2(NUM_TOG + 1);

  spi_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   cur_id_q, cur_id_d;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TOG_W-1:0]   tog_q, tog_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   done_id_q, done_id_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               sclk_q, sclk_d;
  logic               cs_q, cs_d;
  logic               mosi_q, mosi_d;

  logic [NUM_REQ-1:0] arb_gnt_c;
  logic [IDX_W-1:0]   arb_idx_c;
  logic               arb_any_c;
  logic [DATA_W-1:0]  tx_sel_c;
  logic               rx_bit_c;
  logic [TOG_W-1:0]   tog_nxt_c;
  logic               div_hit_c;
  logic [DATA_W-1:0]  rx_shift_c;

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .en    (state_q == ST_IDLE),
    .gnt_c (arb_gnt_c),
    .idx_c (arb_idx_c)
  );

  assign arb_any_c = |arb_gnt_c;

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_bit_c    = mosi_q;
`else
  assign rx_bit_c    = miso;
`endif

  assign tog_nxt_c  = tog_q + TOG_W'(1);
  assign div_hit_c  = (cnt_q == CNT_W'(DIV - 1));
  assign rx_shift_c = {rx_q[DATA_W-2:0], rx_bit_c};

  // Mux the granted requester's byte (grant vector is one-hot).
  always_comb begin
    tx_sel_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt_c[i]) begin
        tx_sel_c = tx_sel_c | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cur_id_d  = cur_id_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    tog_d     = tog_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any_c) begin
          tx_d     = tx_sel_c;
          rx_d     = '0;
          gnt_d    = arb_gnt_c;
          cs_d     = 1'b0;
          mosi_d   = tx_sel_c[DATA_W-1];
          busy_d   = 1'b1;
          cnt_d    = '0;
          tog_d    = '0;
          cur_id_d = arb_idx_c;
          ptr_d    = (arb_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : IDX_W'(arb_idx_c + IDX_W'(1));
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (div_hit_c) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          tog_d   = TOG_W'(1);
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        if (div_hit_c) begin
          cnt_d = '0;
          tog_d = tog_nxt_c;
          if (tog_nxt_c[0]) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: capture a bit, then advance or finish.
            sclk_d = 1'b0;
            rx_d   = rx_shift_c;
            if (tog_nxt_c == TOG_W'(NUM_TOG)) begin
              rx_data_d = rx_shift_c;
              done_d    = 1'b1;
              done_id_d = cur_id_q;
              cs_d      = 1'b1;
              mosi_d    = 1'b0;
              state_d   = ST_HOLD;
            end else begin
              tx_d   = {tx_q[DATA_W-2:0], tx_q[DATA_W-1]};
              mosi_d = tx_q[DATA_W-2];
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_q == CNT_W'(GAP - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cur_id_q  <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
      tog_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cur_id_q  <= cur_id_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      tog_q     <= tog_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign cs      = cs_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb: vector table plus reset, back-to-back,
// and late-request sequences. Honours SPI_LOOPBACK_EN when defined.
module tb_spi_master_arb;

  localparam int NUM_REQ  = 2;
  localparam int DATA_W   = 8;
  localparam int CLK_DIV  = 4;
  localparam int CS_GAP   = 2;
  localparam int XFER_CYC = 2 * DATA_W * CLK_DIV;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  gnt;
  logic        busy;
  logic        done;
  logic [0:0]  done_id;
  logic [7:0]  rx_data;
  logic        sclk;
  logic        cs;
  logic        mosi;
  logic        miso;

  int checks   = 0;
  int failures = 0;

  spi_master_arb #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .rx_data  (rx_data),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] miso_b;
    int         chg_cyc;
    logic [7:0] chg_val;
    logic [1:0] exp_gnt;
    logic       exp_id;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(input int bound, output logic [1:0] g, output int waited);
    g = '0;
    waited = 0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        g = gnt;
        waited = c;
        break;
      end
    end
  endtask

  // Called on the negedge right after the grant edge; acts as the SPI slave.
  task automatic run_xfer(input logic [7:0] miso_b, input int chg_cyc, input logic [7:0] chg_val,
                          output logic [7:0] mosi_b, output int lat);
    logic [7:0] ms;
    logic       sclk_prev;
    ms        = miso_b;
    sclk_prev = 1'b0;
    mosi_b    = '0;
    lat       = 0;
    miso      = ms[7];
    for (int c = 1; c <= XFER_CYC + 40; c++) begin
      @(negedge clk);
      if (c == chg_cyc) req_data[7:0] = chg_val;
      if (sclk && !sclk_prev) mosi_b = {mosi_b[6:0], mosi};
      if (!sclk && sclk_prev) begin
        ms   = {ms[6:0], 1'b0};
        miso = ms[7];
      end
`ifdef SPI_LOOPBACK_EN
      miso = 1'($urandom_range(0, 1));
`endif
      sclk_prev = sclk;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int cyc, output int cs_low);
    cyc = 0;
    cs_low = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!cs && busy) cs_low++;
      if (!busy) begin
        cyc = c;
        break;
      end
    end
  endtask

  initial begin
    logic [1:0] g;
    int         w;
    int         lat;
    int         hold;
    int         cs_low;
    int         gap;
    int         cs_hi;
    int         dones;
    int         extra_g;
    logic [7:0] mb;
    logic [7:0] exp_rx;
    logic [1:0] seq_gnt [2];
    logic [7:0] seq_byte [3];

    req      = '0;
    req_data = '0;
    miso     = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_sclk",    32'(sclk),    32'd0);
    chk("rst_cs",      32'(cs),      32'd1);
    chk("rst_mosi",    32'(mosi),    32'd0);
    chk("rst_gnt",     32'(gnt),     32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;

    vecs[0] = '{2'b01, 8'hA5, 8'h00, 8'h3C, 0, 8'h00, 2'b01, 1'b0, 8'hA5, 8'h3C};
    vecs[1] = '{2'b11, 8'h0F, 8'hF0, 8'h96, 0, 8'h00, 2'b10, 1'b1, 8'hF0, 8'h96};
    vecs[2] = '{2'b11, 8'h0F, 8'hF0, 8'h55, 0, 8'h00, 2'b01, 1'b0, 8'h0F, 8'h55};
    vecs[3] = '{2'b01, 8'h5A, 8'h00, 8'hC3, 0, 8'h00, 2'b01, 1'b0, 8'h5A, 8'hC3};
    vecs[4] = '{2'b10, 8'h00, 8'h81, 8'h00, 0, 8'h00, 2'b10, 1'b1, 8'h81, 8'h00};
    vecs[5] = '{2'b10, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 2'b10, 1'b1, 8'hFF, 8'hFF};
    vecs[6] = '{2'b01, 8'h81, 8'h00, 8'h81, 5, 8'hFF, 2'b01, 1'b0, 8'h81, 8'h81};

    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      req      = vecs[v].req;
      req_data = {vecs[v].d1, vecs[v].d0};
      wait_gnt(20, g, w);
      chk($sformatf("v%0d_gnt", v),  32'(g),    32'(vecs[v].exp_gnt));
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
      chk($sformatf("v%0d_cs", v),   32'(cs),   32'd0);
      req = '0;
      run_xfer(vecs[v].miso_b, vecs[v].chg_cyc, vecs[v].chg_val, mb, lat);
`ifdef SPI_LOOPBACK_EN
      exp_rx = vecs[v].exp_mosi;
`else
      exp_rx = vecs[v].exp_rx;
`endif
      chk($sformatf("v%0d_latency", v), 32'(lat),     32'(XFER_CYC));
      chk($sformatf("v%0d_mosi", v),    32'(mb),      32'(vecs[v].exp_mosi));
      chk($sformatf("v%0d_rx", v),      32'(rx_data), 32'(exp_rx));
      chk($sformatf("v%0d_done_id", v), 32'(done_id), 32'(vecs[v].exp_id));
      chk($sformatf("v%0d_cs_end", v),  32'(cs),      32'd1);
      chk($sformatf("v%0d_sclk_end", v),32'(sclk),    32'd0);
      wait_idle(hold, cs_low);
      chk($sformatf("v%0d_hold", v),    32'(hold),    32'(CS_GAP));
      chk($sformatf("v%0d_cs_hold", v), 32'(cs_low),  32'd0);
    end

    // Reset in the middle of a shift aborts at that edge and resets the pointer.
    @(negedge clk);
    req      = 2'b10;
    req_data = {8'h77, 8'h00};
    wait_gnt(20, g, w);
    chk("rst_mid_gnt", 32'(g), 32'b10);
    req = '0;
    dones = 0;
    repeat (19) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_cs",   32'(cs),   32'd1);
    chk("rst_mid_sclk", 32'(sclk), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rst_mid_no_done", 32'(dones), 32'd0);

    // Both requesters held: grants alternate with a fixed cs gap.
    req         = 2'b11;
    req_data    = {8'h22, 8'h11};
    seq_gnt[0]  = 2'b10;
    seq_gnt[1]  = 2'b01;
    seq_byte[0] = 8'h11;
    seq_byte[1] = 8'h22;
    seq_byte[2] = 8'h11;
    wait_gnt(20, g, w);
    chk("b2b_gnt0", 32'(g), 32'b01);
    for (int n = 0; n < 2; n++) begin
      run_xfer(8'h00, 0, 8'h00, mb, lat);
      chk($sformatf("b2b%0d_latency", n), 32'(lat), 32'(XFER_CYC));
      chk($sformatf("b2b%0d_mosi", n),    32'(mb),  32'(seq_byte[n]));
      gap   = 0;
      cs_hi = 1;
      g     = '0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (gnt != 2'b00) begin
          g   = gnt;
          gap = c;
          break;
        end
        if (cs) cs_hi++;
      end
      chk($sformatf("b2b%0d_gap", n),   32'(gap),              32'(CS_GAP + 1));
      chk($sformatf("b2b%0d_gnt", n),   32'(g),                32'(seq_gnt[n]));
      chk($sformatf("b2b%0d_cs_hi", n), 32'(cs_hi >= CS_GAP),  32'd1);
    end
    req = '0;
    run_xfer(8'h00, 0, 8'h00, mb, lat);
    chk("b2b2_mosi", 32'(mb), 32'(seq_byte[2]));
    wait_idle(hold, cs_low);
    chk("b2b2_hold", 32'(hold), 32'(CS_GAP));

    // Request raised and dropped while busy is never served.
    @(negedge clk);
    req      = 2'b01;
    req_data = {8'h99, 8'h42};
    wait_gnt(20, g, w);
    chk("late_first_gnt", 32'(g), 32'b01);
    req     = '0;
    extra_g = 0;
    dones   = 0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (c == 10) req = 2'b10;
      if (c == 30) req = 2'b00;
      if (gnt != 2'b00) extra_g++;
      if (done) dones++;
    end
    chk("late_no_gnt",  32'(extra_g), 32'd0);
    chk("late_one_done",32'(dones),   32'd1);
    chk("late_idle",    32'(busy),    32'd0);
    chk("late_cs_idle", 32'(cs),      32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
